// File: rtl/l2_sram_memory_slave.sv
// rtl/l2_sram_memory_slave.sv - L2 arbiter memory-side slave driving a 1-cycle-latency single-port SRAM
module l2_sram_memory_slave #(
    parameter int ID_W       = 3,
    parameter int MEM_ADDR_W = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [29:0]           addr,
    input  logic                  rnw,
    input  logic                  is_amo,
    input  logic [4:0]            amo_type_or_burst_size,
    input  logic [ID_W-1:0]       id,
    input  logic                  request_valid,
    input  logic                  abort_request,
    output logic                  request_pop,
    input  logic [31:0]           wr_data,
    input  logic [3:0]            wr_data_be,
    input  logic                  wr_data_valid,
    output logic                  wr_data_read,
    output logic [31:0]           rd_data,
    output logic [ID_W-1:0]       rd_id,
    output logic                  rd_data_valid,
    output logic                  sram_en,
    output logic [3:0]            sram_we,
    output logic [MEM_ADDR_W-1:0] sram_addr,
    output logic [31:0]           sram_wdata,
    input  logic [31:0]           sram_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam logic [MEM_ADDR_W-1:0] ADDR_ONE = 1;

    state_t                  state;
    logic [MEM_ADDR_W-1:0]   cur_addr;
    logic [4:0]              remaining;
    logic [ID_W-1:0]         cur_id;
    logic                    rd_valid_q;
    logic [ID_W-1:0]         rd_id_q;

    logic                    rd_issue;
    logic                    wr_beat;
    logic                    last_beat;

    // AMO requests execute as plain reads/writes; upper address bits alias.
    logic unused_inputs;
    assign unused_inputs = ^{is_amo, addr[29:MEM_ADDR_W]};

    assign rd_issue  = !rst && (state == READ);
    assign wr_beat   = !rst && (state == WRITE) && wr_data_valid;
    assign last_beat = (remaining == 5'd0);

    assign request_pop   = !rst && (state == IDLE) && request_valid;
    assign wr_data_read  = wr_beat;

    assign sram_en    = rd_issue | wr_beat;
    assign sram_we    = wr_beat ? wr_data_be : 4'b0000;
    assign sram_addr  = (rd_issue | wr_beat) ? cur_addr : '0;
    assign sram_wdata = wr_beat ? wr_data : 32'h0;

    // SRAM data arrives the cycle after issue, aligned with the registered valid.
    assign rd_data_valid = rd_valid_q;
    assign rd_data       = rd_valid_q ? sram_rdata : 32'h0;
    assign rd_id         = rd_id_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cur_addr   <= '0;
            remaining  <= 5'd0;
            cur_id     <= '0;
            rd_valid_q <= 1'b0;
            rd_id_q    <= '0;
        end else begin
            rd_valid_q <= rd_issue;
            if (rd_issue) begin
                rd_id_q <= cur_id;
            end
            case (state)
                IDLE: begin
                    if (request_valid && !abort_request) begin
                        cur_addr  <= addr[MEM_ADDR_W-1:0];
                        cur_id    <= id;
                        remaining <= amo_type_or_burst_size;
                        state     <= rnw ? READ : WRITE;
                    end
                end
                READ: begin
                    cur_addr  <= cur_addr + ADDR_ONE;
                    remaining <= remaining - 5'd1;
                    if (last_beat) begin
                        state <= IDLE;
                    end
                end
                WRITE: begin
                    if (wr_data_valid) begin
                        cur_addr  <= cur_addr + ADDR_ONE;
                        remaining <= remaining - 5'd1;
                        if (last_beat) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l2_sram_memory_slave.sv
// tb/tb_l2_sram_memory_slave.sv - scoreboard bench for l2_sram_memory_slave
module tb_l2_sram_memory_slave;

    localparam int ID_W       = 3;
    localparam int MEM_ADDR_W = 14;
    localparam int DEPTH      = 1 << MEM_ADDR_W;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [29:0]           addr;
    logic                  rnw;
    logic                  is_amo;
    logic [4:0]            amo_type_or_burst_size;
    logic [ID_W-1:0]       id;
    logic                  request_valid;
    logic                  abort_request;
    logic                  request_pop;
    logic [31:0]           wr_data;
    logic [3:0]            wr_data_be;
    logic                  wr_data_valid;
    logic                  wr_data_read;
    logic [31:0]           rd_data;
    logic [ID_W-1:0]       rd_id;
    logic                  rd_data_valid;
    logic                  sram_en;
    logic [3:0]            sram_we;
    logic [MEM_ADDR_W-1:0] sram_addr;
    logic [31:0]           sram_wdata;
    logic [31:0]           sram_rdata;

    l2_sram_memory_slave #(.ID_W(ID_W), .MEM_ADDR_W(MEM_ADDR_W)) dut (
        .clk(clk), .rst(rst), .addr(addr), .rnw(rnw), .is_amo(is_amo),
        .amo_type_or_burst_size(amo_type_or_burst_size), .id(id),
        .request_valid(request_valid), .abort_request(abort_request),
        .request_pop(request_pop), .wr_data(wr_data), .wr_data_be(wr_data_be),
        .wr_data_valid(wr_data_valid), .wr_data_read(wr_data_read),
        .rd_data(rd_data), .rd_id(rd_id), .rd_data_valid(rd_data_valid),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]     data;
        logic [ID_W-1:0] id;
    } exp_t;

    logic [31:0]           mem     [DEPTH];
    logic [31:0]           ref_mem [DEPTH];
    exp_t                  exp_q[$];
    logic [MEM_ADDR_W-1:0] addr_log[$];

    int n_checks    = 0;
    int n_errors    = 0;
    int cyc         = 0;
    int valid_cnt   = 0;
    int first_valid = -1;
    int en_cnt      = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we == 4'b0000) begin
                sram_rdata <= mem[sram_addr];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (sram_we[b]) mem[sram_addr][8*b +: 8] = sram_wdata[8*b +: 8];
                end
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sram_en) en_cnt++;
        if (sram_en && sram_we == 4'b0000) addr_log.push_back(sram_addr);
        if (rd_data_valid) begin
            exp_t e;
            valid_cnt++;
            if (first_valid < 0) first_valid = cyc;
            if (exp_q.size() == 0) begin
                check("rd_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("rd_data", rd_data, e.data);
                check("rd_id", rd_id, e.id);
            end
        end
    end

    task automatic send_req(input logic [29:0] a, input logic r, input logic [4:0] sz,
                            input logic [ID_W-1:0] i, input logic ab, output int pc);
        bit got = 0;
        pc = -1;
        addr = a; rnw = r; amo_type_or_burst_size = sz; id = i; abort_request = ab;
        is_amo = r;
        request_valid = 1'b1;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (request_pop) begin
                got = 1;
                pc  = cyc;
            end
            @(posedge clk); #1;
        end
        if (!got) check("pop_timeout", 0, 1);
        request_valid = 1'b0;
        abort_request = 1'b0;
        is_amo        = 1'b0;
        if (got && r && !ab) begin
            for (int b = 0; b <= int'(sz); b++) begin
                exp_q.push_back('{ref_mem[(int'(a[MEM_ADDR_W-1:0]) + b) % DEPTH], i});
            end
        end
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(negedge clk);
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pc, p1, p2, pulses, beat, e0;
        logic [5:0] pat;
        logic [MEM_ADDR_W-1:0] wrap_exp [4];
        logic [MEM_ADDR_W-1:0] got_a;

        for (int k = 0; k < DEPTH; k++) begin
            mem[k]     = 32'(k) * 32'h0001_0003 ^ 32'h5A00_0000;
            ref_mem[k] = mem[k];
        end
        rst = 1'b1; addr = '0; rnw = 1'b0; is_amo = 1'b0; amo_type_or_burst_size = '0;
        id = '0; request_valid = 1'b1; abort_request = 1'b0;
        wr_data = '0; wr_data_be = '0; wr_data_valid = 1'b0;

        // Reset: outputs quiet even with a request presented
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rd_valid", rd_data_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_id", rd_id, 0);
        check("rst_pop", request_pop, 0);
        check("rst_sram_en", sram_en, 0);
        @(posedge clk); #1;
        rst = 1'b0; request_valid = 1'b0;

        // Single-beat read latency
        mem[16'h10] = 32'hA5A5_0001; ref_mem[16'h10] = 32'hA5A5_0001;
        first_valid = -1; valid_cnt = 0;
        send_req(30'h10, 1'b1, 5'd0, 3'd5, 1'b0, pc);
        wait_drain();
        repeat (3) @(negedge clk);
        check("t1_latency", first_valid - pc, 2);
        check("t1_beats", valid_cnt, 1);

        // 8-beat burst then back-to-back request
        @(posedge clk); #1;
        valid_cnt = 0;
        send_req(30'h20, 1'b1, 5'd7, 3'd3, 1'b0, p1);
        send_req(30'h30, 1'b1, 5'd0, 3'd6, 1'b0, p2);
        check("b2b_gap", p2 - p1, 9);
        wait_drain();
        repeat (2) @(negedge clk);
        check("t2_beats", valid_cnt, 9);

        // Write burst with stalls and partial byte enables
        @(posedge clk); #1;
        mem[16'h40] = 32'h1122_3344; ref_mem[16'h40] = 32'h1122_3344;
        send_req(30'h40, 1'b0, 5'd3, 3'd2, 1'b0, pc);
        pat = 6'b101101;
        pulses = 0; beat = 0;
        for (int k = 0; k < 6; k++) begin
            wr_data_valid = pat[k];
            wr_data       = 32'hCAFE_0000 + 32'(k);
            wr_data_be    = (beat == 0) ? 4'b0101 : 4'b1111;
            @(negedge clk);
            check("wr_read", wr_data_read, pat[k]);
            if (wr_data_read) pulses++;
            if (pat[k]) begin
                if (beat == 0) check("wr_we0", sram_we, 4'b0101);
                check("wr_addr", sram_addr, 14'h40 + 14'(beat));
                for (int b = 0; b < 4; b++)
                    if (wr_data_be[b]) ref_mem[16'h40 + beat][8*b +: 8] = wr_data[8*b +: 8];
                beat++;
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("wr_after_idle", wr_data_read, 0);
        check("wr_pulses", pulses, 4);
        @(posedge clk); #1;
        wr_data_valid = 1'b0;
        send_req(30'h40, 1'b1, 5'd3, 3'd1, 1'b0, pc);
        wait_drain();

        // Abort at pop: no access, no data
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        e0 = en_cnt; valid_cnt = 0;
        send_req(30'h10, 1'b1, 5'd0, 3'd4, 1'b1, pc);
        check("abort_popped", pc >= 0, 1);
        repeat (4) @(negedge clk);
        check("abort_no_en", en_cnt - e0, 0);
        check("abort_no_rd", valid_cnt, 0);

        // Address wrap with aliased upper bits
        @(posedge clk); #1;
        addr_log.delete();
        wrap_exp[0] = 14'(DEPTH - 2); wrap_exp[1] = 14'(DEPTH - 1);
        wrap_exp[2] = 14'd0;          wrap_exp[3] = 14'd1;
        send_req(30'h2000_0000 | 30'(DEPTH - 2), 1'b1, 5'd3, 3'd7, 1'b0, pc);
        wait_drain();
        check("wrap_count", addr_log.size(), 4);
        for (int k = 0; k < 4; k++) begin
            got_a = (addr_log.size() > 0) ? addr_log.pop_front() : '1;
            check("wrap_addr", got_a, wrap_exp[k]);
        end

        // Reset mid-burst after 4 issued beats
        @(posedge clk); #1;
        valid_cnt = 0;
        send_req(30'h100, 1'b1, 5'd15, 3'd6, 1'b0, pc);
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1; request_valid = 1'b1;
        @(negedge clk);
        check("rst_mid_en", sram_en, 0);
        check("rst_mid_pop", request_pop, 0);
        @(posedge clk); #1;
        rst = 1'b0; request_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", rd_data_valid, 0);
        check("rst_mid_beats", valid_cnt, 4);
        exp_q.delete();
        repeat (3) @(negedge clk);
        check("rst_quiet", valid_cnt, 4);

        // Normal service after reset
        @(posedge clk); #1;
        valid_cnt = 0;
        send_req(30'h20, 1'b1, 5'd1, 3'd2, 1'b0, pc);
        wait_drain();
        repeat (2) @(negedge clk);
        check("post_rst_beats", valid_cnt, 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
